// File: rtl/mem_access_ctrl.sv
// LC-3 memory access sequencer: IDLE -> SETUP -> ACCESS -> DONE per request.
// Define MEM_TIMEOUT_EN to bound ACCESS to TIMEOUT_CYCLES and flag err.
module mem_access_ctrl #(
  parameter int WAIT_STATES    = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        rd_req,
  input  logic        wr_req,
  input  logic [15:0] MAR,
  input  logic [15:0] MDR,
  input  logic        mem_ready,
  input  logic [15:0] mem_rdata,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        CE_n,
  output logic        OE_n,
  output logic        WE_n,
  output logic [15:0] MDR_In,
  output logic        R,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } state_t;

  localparam int CW =
    (WAIT_STATES < 1) ? 1 : $clog2(WAIT_STATES + 1);
  localparam logic [CW-1:0] WS_MAX = CW'(WAIT_STATES);

  state_t        state;
  logic          op_rd;
  logic [CW-1:0] wcnt;
  logic          ws_done;
  logic          to_hit;
  logic          req;

  assign req     = rd_req | wr_req;
  assign ws_done = (wcnt == WS_MAX) && mem_ready;

`ifdef MEM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST =
    TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tcnt;
  logic          err_q;

  // A normal completion on the last allowed cycle wins over the timeout.
  assign to_hit = (tcnt == TO_LAST) && !ws_done;
  assign err    = err_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      tcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) err_q <= 1'b0;
        end
        SETUP: begin
          tcnt <= '0;
        end
        ACCESS: begin
          if (to_hit) err_q <= 1'b1;
          else if (!ws_done) tcnt <= tcnt + 1'b1;
        end
        default: ;
      endcase
    end
  end
`else
  logic unused_to;

  assign to_hit    = 1'b0;
  assign err       = 1'b0;
  assign unused_to = (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      op_rd     <= 1'b0;
      wcnt      <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      MDR_In    <= '0;
      CE_n      <= 1'b1;
      OE_n      <= 1'b1;
      WE_n      <= 1'b1;
      R         <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            state     <= SETUP;
            op_rd     <= rd_req;
            mem_addr  <= MAR;
            mem_wdata <= MDR;
            CE_n      <= 1'b0;
            OE_n      <= !rd_req;
            WE_n      <= 1'b1;
            busy      <= 1'b1;
          end
        end
        SETUP: begin
          // Address has been stable a full cycle; WE_n may fall now.
          state <= ACCESS;
          wcnt  <= '0;
          CE_n  <= 1'b0;
          OE_n  <= !op_rd;
          WE_n  <= op_rd;
        end
        ACCESS: begin
          if (ws_done || to_hit) begin
            state <= DONE;
            CE_n  <= 1'b1;
            OE_n  <= 1'b1;
            WE_n  <= 1'b1;
            R     <= 1'b1;
            if (op_rd) begin
              MDR_In <= ws_done ? mem_rdata : 16'hDEAD;
            end
          end else if (wcnt != WS_MAX) begin
            wcnt <= wcnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          R     <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a scoreboard of completions.
// Timeout case runs only when MEM_TIMEOUT_EN is defined.
module tb_mem_access_ctrl;

  localparam int WS = 2;
  localparam int TO = 8;
`ifdef MEM_TIMEOUT_EN
  localparam int SLOW_AT = 7;
`else
  localparam int SLOW_AT = 14;
`endif

  logic        Clk;
  logic        Reset_n;
  logic        rd_req;
  logic        wr_req;
  logic [15:0] MAR;
  logic [15:0] MDR;
  logic        mem_ready;
  logic [15:0] mem_rdata;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        CE_n;
  logic        OE_n;
  logic        WE_n;
  logic [15:0] MDR_In;
  logic        R;
  logic        busy;
  logic        err;

  mem_access_ctrl #(
    .WAIT_STATES   (WS),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .rd_req   (rd_req),
    .wr_req   (wr_req),
    .MAR      (MAR),
    .MDR      (MDR),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .CE_n     (CE_n),
    .OE_n     (OE_n),
    .WE_n     (WE_n),
    .MDR_In   (MDR_In),
    .R        (R),
    .busy     (busy),
    .err      (err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] mdr;
    logic        err;
    int          rcyc;
  } exp_t;

  exp_t        sbq[$];
  logic [15:0] mdr_model;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic do_access(input string tag,
                           input logic rd,
                           input logic wr,
                           input logic [15:0] addr,
                           input logic [15:0] wdata,
                           input logic [15:0] rdata,
                           input int ready_at,
                           input logic repulse,
                           input logic exp_err);
    exp_t e;
    int   rexp;
    int   r_first;
    int   r_cnt;
    int   oe_low;
    int   we_low;
    int   ce_low;
    logic is_rd;
    is_rd = rd;
    if (ready_at < 0) rexp = 2 + TO;
    else rexp = ((ready_at > WS + 2) ? ready_at : WS + 2) + 1;
    if (is_rd) mdr_model = exp_err ? 16'hDEAD : rdata;
    e.addr  = addr;
    e.wdata = wdata;
    e.mdr   = mdr_model;
    e.err   = exp_err;
    e.rcyc  = rexp;
    sbq.push_back(e);
    rd_req    = rd;
    wr_req    = wr;
    MAR       = addr;
    MDR       = wdata;
    mem_rdata = rdata;
    mem_ready = (ready_at == 0);
    @(posedge Clk);
    @(negedge Clk);
    rd_req  = 1'b0;
    wr_req  = 1'b0;
    r_first = 0;
    r_cnt   = 0;
    oe_low  = 0;
    we_low  = 0;
    ce_low  = 0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (!OE_n) oe_low++;
      if (!WE_n) we_low++;
      if (!CE_n) ce_low++;
      if (cyc == 1) begin
        check({tag, "_we_setup"}, 32'(WE_n), 32'd1);
        check({tag, "_busy_setup"}, 32'(busy), 32'd1);
        check({tag, "_err_accept"}, 32'(err), 32'd0);
      end
      if (R) begin
        r_cnt++;
        if (r_first == 0) begin
          r_first = cyc;
          check({tag, "_sb_depth"}, 32'(sbq.size()), 32'd1);
          if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check({tag, "_rcyc"}, 32'(cyc), 32'(e.rcyc));
            check({tag, "_mdr_in"}, 32'(MDR_In), 32'(e.mdr));
            check({tag, "_addr"}, 32'(mem_addr), 32'(e.addr));
            check({tag, "_wdata"}, 32'(mem_wdata), 32'(e.wdata));
            check({tag, "_err"}, 32'(err), 32'(e.err));
          end
        end
      end
      if (r_first != 0 && cyc == r_first + 1)
        check({tag, "_busy_idle"}, 32'(busy), 32'd0);
      if (r_first != 0 && cyc == r_first + 2) break;
      if (cyc == ready_at) mem_ready = 1'b1;
      if (repulse && cyc == 2) begin
        rd_req = 1'b1;
        wr_req = 1'b1;
      end
      if (repulse && cyc == 3) begin
        rd_req = 1'b0;
        wr_req = 1'b0;
      end
      @(posedge Clk);
      @(negedge Clk);
    end
    check({tag, "_r_seen"}, 32'(r_first), 32'(rexp));
    check({tag, "_r_count"}, 32'(r_cnt), 32'd1);
    check({tag, "_ce_low"}, 32'(ce_low), 32'(rexp - 1));
    check({tag, "_oe_low"}, 32'(oe_low), is_rd ? 32'(rexp - 1) : 32'd0);
    check({tag, "_we_low"}, 32'(we_low), is_rd ? 32'd0 : 32'(rexp - 2));
    mem_ready = 1'b0;
  endtask

  initial begin
    int r_cnt;
    Reset_n   = 1'b0;
    rd_req    = 1'b0;
    wr_req    = 1'b0;
    MAR       = '0;
    MDR       = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    mdr_model = '0;
    #12;
    check("rst_ce", 32'(CE_n), 32'd1);
    check("rst_oe", 32'(OE_n), 32'd1);
    check("rst_we", 32'(WE_n), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_r", 32'(R), 32'd0);
    check("rst_mdr", 32'(MDR_In), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);

    do_access("rd", 1'b1, 1'b0, 16'h3000, 16'h0000,
              16'h1234, 0, 1'b0, 1'b0);

    // Reset in the middle of SETUP
    rd_req    = 1'b1;
    MAR       = 16'h5000;
    mem_ready = 1'b1;
    mem_rdata = 16'h9999;
    @(posedge Clk);
    @(negedge Clk);
    rd_req = 1'b0;
    check("mid_setup_ce", 32'(CE_n), 32'd0);
    #2 Reset_n = 1'b0;
    #1;
    check("mid_rst_ce", 32'(CE_n), 32'd1);
    check("mid_rst_oe", 32'(OE_n), 32'd1);
    check("mid_rst_we", 32'(WE_n), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_r", 32'(R), 32'd0);
    check("mid_rst_mdr", 32'(MDR_In), 32'd0);
    mdr_model = '0;
    @(negedge Clk);
    Reset_n = 1'b1;
    r_cnt   = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      if (R) r_cnt++;
    end
    check("mid_rst_no_r", 32'(r_cnt), 32'd0);
    check("mid_rst_idle", 32'(busy), 32'd0);
    mem_ready = 1'b0;

    do_access("wr", 1'b0, 1'b1, 16'h0042, 16'hBEEF,
              16'h7777, 0, 1'b0, 1'b0);
    do_access("both", 1'b1, 1'b1, 16'h1111, 16'hABCD,
              16'h55AA, 0, 1'b1, 1'b0);
    do_access("slow", 1'b1, 1'b0, 16'h2222, 16'h0000,
              16'h0F0F, SLOW_AT, 1'b0, 1'b0);
    do_access("slow_wr", 1'b0, 1'b1, 16'h2400, 16'h6161,
              16'h0000, 6, 1'b0, 1'b0);
`ifdef MEM_TIMEOUT_EN
    do_access("tmo", 1'b1, 1'b0, 16'h3300, 16'h0000,
              16'h1357, -1, 1'b0, 1'b1);
    check("tmo_err_hold", 32'(err), 32'd1);
    do_access("after_tmo", 1'b1, 1'b0, 16'h4444, 16'h0000,
              16'hCAFE, 0, 1'b0, 1'b0);
`endif
    check("sb_drained", 32'(sbq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
